// File: rtl/lsu_mem_master.sv
// -----------------------------------------------------------------------------
// lsu_mem_master
//   Load/store initiator between the MEM pipeline stage and a 64-bit,
//   word-addressed data memory. It takes one byte-addressed access per
//   handshake, drives the memory read/write strobes, and returns a sized,
//   extended load result. Stores narrower than a doubleword are done as
//   read-modify-write because the memory has no byte enables. Misaligned
//   or unsupported accesses are reported with resp_err and never touch memory.
//
// Ports
//   clk, reset_n       clock (rising edge), asynchronous active-low reset
//   req_valid/ready    request handshake; ready only while idle
//   req_write          1 = store, 0 = load
//   req_funct3         RV64 load/store funct3 (size + signedness)
//   req_addr           byte address (bits above the memory span are ignored)
//   req_wdata          right-aligned store data
//   resp_valid         one-cycle completion pulse
//   resp_rdata         extended load data (0 for stores / errors / idle)
//   resp_err           misaligned or unsupported access, valid with resp_valid
//   mem_addr           doubleword index
//   mem_write_data     word to write
//   mem_write          write strobe (memory writes on the clk edge)
//   mem_read           read enable (read data is combinational)
//   mem_read_data      read data from memory (0 when mem_read is low)
// -----------------------------------------------------------------------------
module lsu_mem_master #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 10,
  parameter int XLEN       = 64
) (
  input  logic                  clk,
  input  logic                  reset_n,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic                  req_write,
  input  logic [2:0]            req_funct3,
  input  logic [XLEN-1:0]       req_addr,
  input  logic [DATA_WIDTH-1:0] req_wdata,
  output logic                  resp_valid,
  output logic [DATA_WIDTH-1:0] resp_rdata,
  output logic                  resp_err,
  output logic [ADDR_WIDTH-1:0] mem_addr,
  output logic [DATA_WIDTH-1:0] mem_write_data,
  output logic                  mem_write,
  output logic                  mem_read,
  input  logic [DATA_WIDTH-1:0] mem_read_data
);

  // Byte-address bits that matter: word index plus the 3-bit byte offset.
  localparam int AW = ADDR_WIDTH + 3;

  typedef enum logic [1:0] {
    S_IDLE,
    S_ACCESS,
    S_WRITE,
    S_RESP
  } state_t;

  state_t                r_state;
  state_t                w_next_state;

  logic                  r_write;
  logic [2:0]            r_funct3;
  logic [AW-1:0]         r_addr;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [DATA_WIDTH-1:0] r_rdata;
  logic [DATA_WIDTH-1:0] r_merged;
  logic                  r_err;

  logic                  w_fire;
  logic                  w_unsupported;
  logic                  w_misaligned;
  logic                  w_req_err;
  logic                  w_is_sd;
  logic [5:0]            w_lane_shift;
  logic [DATA_WIDTH-1:0] w_lane;
  logic [DATA_WIDTH-1:0] w_load_data;
  logic [DATA_WIDTH-1:0] w_mask;
  logic [DATA_WIDTH-1:0] w_merged;

  // Upper address bits wrap away; reduce them so the intent is explicit.
  logic w_unused_addr;
  assign w_unused_addr = ^req_addr[XLEN-1:AW];

  assign w_fire = req_valid && req_ready;

  // ---------------------------------------------------------------------------
  // Request classification (evaluated on the live request in IDLE)
  // ---------------------------------------------------------------------------
  // NOTE: every signal assigned in always_comb gets a default first so no
  // path leaves it unassigned -- otherwise synthesis infers a latch.
  always_comb begin
    w_unsupported = 1'b0;
    w_misaligned  = 1'b0;
    if (req_write) w_unsupported = req_funct3[2];
    else           w_unsupported = (req_funct3 == 3'b111);
    case (req_funct3[1:0])
      2'b01:   w_misaligned = req_addr[0];
      2'b10:   w_misaligned = |req_addr[1:0];
      2'b11:   w_misaligned = |req_addr[2:0];
      default: w_misaligned = 1'b0;
    endcase
  end

  assign w_req_err = w_unsupported || w_misaligned;

  // After a clean capture the only 8-byte store is SD (funct3 011).
  assign w_is_sd = r_write && (r_funct3 == 3'b011);

  // ---------------------------------------------------------------------------
  // Load lane extraction / store lane merge
  // ---------------------------------------------------------------------------
  assign w_lane_shift = {r_addr[2:0], 3'b000};
  assign w_lane       = mem_read_data >> w_lane_shift;

  always_comb begin
    w_load_data = '0;
    case (r_funct3)
      3'b000:  w_load_data = {{56{w_lane[7]}},  w_lane[7:0]};
      3'b001:  w_load_data = {{48{w_lane[15]}}, w_lane[15:0]};
      3'b010:  w_load_data = {{32{w_lane[31]}}, w_lane[31:0]};
      3'b011:  w_load_data = w_lane;
      3'b100:  w_load_data = {56'd0, w_lane[7:0]};
      3'b101:  w_load_data = {48'd0, w_lane[15:0]};
      3'b110:  w_load_data = {32'd0, w_lane[31:0]};
      default: w_load_data = '0;
    endcase
  end

  always_comb begin
    w_mask = '1;
    case (r_funct3[1:0])
      2'b00:   w_mask = 64'h0000_0000_0000_00FF;
      2'b01:   w_mask = 64'h0000_0000_0000_FFFF;
      2'b10:   w_mask = 64'h0000_0000_FFFF_FFFF;
      default: w_mask = '1;
    endcase
  end

  // Old word with the addressed lane cleared, then the new low bytes ORed in.
  assign w_merged = (mem_read_data & ~(w_mask << w_lane_shift)) |
                    ((r_wdata & w_mask) << w_lane_shift);

  // ---------------------------------------------------------------------------
  // FSM state register
  // ---------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values regardless of statement order.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) r_state <= S_IDLE;
    else          r_state <= w_next_state;
  end

  // ---------------------------------------------------------------------------
  // FSM next-state and Moore outputs
  // ---------------------------------------------------------------------------
  always_comb begin
    w_next_state   = r_state;
    req_ready      = 1'b0;
    mem_read       = 1'b0;
    mem_write      = 1'b0;
    mem_write_data = '0;
    resp_valid     = 1'b0;
    resp_err       = 1'b0;
    resp_rdata     = '0;
    case (r_state)
      S_IDLE: begin
        req_ready = 1'b1;
        if (w_fire) w_next_state = w_req_err ? S_RESP : S_ACCESS;
      end
      S_ACCESS: begin
        if (w_is_sd) begin
          mem_write      = 1'b1;
          mem_write_data = r_wdata;
          w_next_state   = S_RESP;
        end else begin
          // Loads and the read half of a sub-doubleword store.
          mem_read     = 1'b1;
          w_next_state = r_write ? S_WRITE : S_RESP;
        end
      end
      S_WRITE: begin
        mem_write      = 1'b1;
        mem_write_data = r_merged;
        w_next_state   = S_RESP;
      end
      S_RESP: begin
        resp_valid   = 1'b1;
        resp_err     = r_err;
        resp_rdata   = r_rdata;
        w_next_state = S_IDLE;
      end
      default: w_next_state = S_IDLE;
    endcase
  end

  // mem_addr comes straight from the captured address, so it is stable from
  // ACCESS through WRITE without extra holding logic.
  assign mem_addr = r_addr[AW-1:3];

  // ---------------------------------------------------------------------------
  // Capture / datapath registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_write  <= 1'b0;
      r_funct3 <= '0;
      r_addr   <= '0;
      r_wdata  <= '0;
      r_rdata  <= '0;
      r_merged <= '0;
      r_err    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_fire) begin
            r_write  <= req_write;
            r_funct3 <= req_funct3;
            r_addr   <= req_addr[AW-1:0];
            r_wdata  <= req_wdata;
            r_err    <= w_req_err;
            // Stores and errors respond with zero data.
            r_rdata  <= '0;
          end
        end
        S_ACCESS: begin
          if (!r_write)      r_rdata  <= w_load_data;
          else if (!w_is_sd) r_merged <= w_merged;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_lsu_mem_master.sv
// -----------------------------------------------------------------------------
// tb_lsu_mem_master
//   Self-checking bench for lsu_mem_master: a directed vector table, hand
//   sequences for back-to-back requests and reset during a write, and random
//   requests compared against a byte-level reference model.
// -----------------------------------------------------------------------------
module tb_lsu_mem_master;

  logic        clk;
  logic        reset_n;
  logic        req_valid;
  logic        req_ready;
  logic        req_write;
  logic [2:0]  req_funct3;
  logic [63:0] req_addr;
  logic [63:0] req_wdata;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [9:0]  mem_addr;
  logic [63:0] mem_write_data;
  logic        mem_write;
  logic        mem_read;
  logic [63:0] mem_read_data;

  lsu_mem_master #(.DATA_WIDTH(64), .ADDR_WIDTH(10), .XLEN(64)) dut (
    .clk            (clk),
    .reset_n        (reset_n),
    .req_valid      (req_valid),
    .req_ready      (req_ready),
    .req_write      (req_write),
    .req_funct3     (req_funct3),
    .req_addr       (req_addr),
    .req_wdata      (req_wdata),
    .resp_valid     (resp_valid),
    .resp_rdata     (resp_rdata),
    .resp_err       (resp_err),
    .mem_addr       (mem_addr),
    .mem_write_data (mem_write_data),
    .mem_write      (mem_write),
    .mem_read       (mem_read),
    .mem_read_data  (mem_read_data)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Memory environment (backdoor port for preloading)
  // ---------------------------------------------------------------------------
  logic [63:0] mem [1024];
  logic        bk_we;
  logic [9:0]  bk_idx;
  logic [63:0] bk_data;

  always @(posedge clk) begin
    if (bk_we)          mem[bk_idx]   <= bk_data;
    else if (mem_write) mem[mem_addr] <= mem_write_data;
  end
  assign mem_read_data = mem_read ? mem[mem_addr] : 64'd0;

  // ---------------------------------------------------------------------------
  // Strobe monitor (cumulative counters, sampled on the falling edge)
  // ---------------------------------------------------------------------------
  int          rd_cnt = 0;
  int          wr_cnt = 0;
  int          both_cnt = 0;
  int          addr_bad_cnt = 0;
  int          ready_bad_cnt = 0;
  logic        prev_read = 1'b0;
  logic [9:0]  prev_addr = '0;
  logic [63:0] last_wdata = '0;

  always @(negedge clk) begin
    if (mem_read)  rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt     <= wr_cnt + 1;
      last_wdata <= mem_write_data;
    end
    if (mem_read && mem_write) both_cnt <= both_cnt + 1;
    if (mem_write && prev_read && mem_addr != prev_addr) addr_bad_cnt <= addr_bad_cnt + 1;
    if (req_ready && (mem_read || mem_write || resp_valid)) ready_bad_cnt <= ready_bad_cnt + 1;
    prev_read <= mem_read;
    prev_addr <= mem_addr;
  end

  // ---------------------------------------------------------------------------
  // Checking helpers
  // ---------------------------------------------------------------------------
  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic preload(input logic [9:0] idx, input logic [63:0] data);
    @(negedge clk);
    bk_we   = 1'b1;
    bk_idx  = idx;
    bk_data = data;
    @(posedge clk);
    #1 bk_we = 1'b0;
  endtask

  // One complete access; lat counts falling edges after the handshake edge
  // until resp_valid is seen (1 = the cycle right after the handshake).
  task automatic do_req(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                        input logic [63:0] wdata, output logic [63:0] rdata,
                        output logic err, output int lat, output int drd, output int dwr);
    int rd0, wr0;
    rdata = '1; err = 1'bx; lat = 99;
    @(negedge clk);
    req_valid = 1'b1; req_write = wr; req_funct3 = f3; req_addr = addr; req_wdata = wdata;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    rd0 = rd_cnt; wr0 = wr_cnt;
    #1 req_valid = 1'b0;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (resp_valid) begin
        rdata = resp_rdata; err = resp_err; lat = i;
        break;
      end
    end
    drd = rd_cnt - rd0;
    dwr = wr_cnt - wr0;
  endtask

  // ---------------------------------------------------------------------------
  // Directed vectors
  // ---------------------------------------------------------------------------
  typedef struct {
    logic        wr;
    logic [2:0]  f3;
    logic [63:0] addr;
    logic [63:0] wdata;
    logic [63:0] exp_rdata;
    logic        exp_err;
    int          exp_lat;
    int          exp_rd;
    int          exp_wr;
    logic [63:0] exp_wdata;
  } vec_t;

  vec_t vecs[$];

  task automatic add_vec(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                         input logic [63:0] wdata, input logic [63:0] exp_rdata,
                         input logic exp_err, input int exp_lat, input int exp_rd,
                         input int exp_wr, input logic [63:0] exp_wdata);
    vec_t v;
    v.wr = wr; v.f3 = f3; v.addr = addr; v.wdata = wdata; v.exp_rdata = exp_rdata;
    v.exp_err = exp_err; v.exp_lat = exp_lat; v.exp_rd = exp_rd; v.exp_wr = exp_wr;
    v.exp_wdata = exp_wdata;
    vecs.push_back(v);
  endtask

  // ---------------------------------------------------------------------------
  // Reference model: byte-level view of memory, independent of the RTL
  // ---------------------------------------------------------------------------
  logic [63:0] ref_mem [16];

  task automatic model(input logic wr, input logic [2:0] f3, input logic [63:0] addr,
                       input logic [63:0] wdata, output logic [63:0] rdata,
                       output logic err, output int lat, output int nrd, output int nwr);
    int nbytes, off, idx;
    logic [63:0] word;
    nbytes = 1 << f3[1:0];
    off    = int'(addr % 8);
    idx    = int'((addr / 8) % 1024);
    err    = (wr ? (f3 > 3) : (f3 == 7)) || ((off % nbytes) != 0);
    rdata  = 64'd0;
    if (err) begin
      lat = 1; nrd = 0; nwr = 0;
    end else if (!wr) begin
      word = ref_mem[idx];
      for (int b = 0; b < nbytes; b++) rdata[8*b +: 8] = word[8*(off+b) +: 8];
      if (!f3[2] && nbytes < 8 && rdata[8*nbytes-1]) rdata = rdata | ({64{1'b1}} << (8*nbytes));
      lat = 2; nrd = 1; nwr = 0;
    end else begin
      word = ref_mem[idx];
      for (int b = 0; b < nbytes; b++) word[8*(off+b) +: 8] = wdata[8*b +: 8];
      ref_mem[idx] = word;
      lat = (nbytes == 8) ? 2 : 3;
      nrd = (nbytes == 8) ? 0 : 1;
      nwr = 1;
    end
  endtask

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  logic [63:0] got_rdata, exp_rdata;
  logic        got_err, exp_err;
  int          got_lat, got_rd, got_wr, exp_lat, exp_rd, exp_wr;

  initial begin
    reset_n = 1'b0; req_valid = 1'b0; req_write = 1'b0; req_funct3 = '0;
    req_addr = '0; req_wdata = '0; bk_we = 1'b0; bk_idx = '0; bk_data = '0;

    // Reset state
    #12;
    check("rst_req_ready", req_ready, 1);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_resp_err", resp_err, 0);
    check("rst_resp_rdata", resp_rdata, 0);
    check("rst_mem_read", mem_read, 0);
    check("rst_mem_write", mem_write, 0);
    check("rst_mem_addr", mem_addr, 0);
    check("rst_mem_wdata", mem_write_data, 0);
    @(negedge clk); @(negedge clk);
    reset_n = 1'b1;

    preload(10'd1, 64'd0);
    preload(10'd2, 64'h8877_6655_4433_2211);
    preload(10'd1023, 64'd0);

    //       wr    f3      addr                    wdata                  exp_rdata              err lat rd wr exp_wdata
    add_vec(1'b0, 3'b011, 64'h10,                 64'd0,                 64'h8877665544332211, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b000, 64'h17,                 64'd0,                 64'hFFFFFFFFFFFFFF88, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b100, 64'h17,                 64'd0,                 64'h0000000000000088, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b001, 64'h16,                 64'd0,                 64'hFFFFFFFFFFFF8877, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b110, 64'h14,                 64'd0,                 64'h0000000088776655, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b010, 64'h14,                 64'd0,                 64'hFFFFFFFF88776655, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b101, 64'h12,                 64'd0,                 64'h0000000000004433, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b000, 64'h10,                 64'd0,                 64'h0000000000000011, 0, 2, 1, 0, 64'd0);
    add_vec(1'b1, 3'b000, 64'h0B,                 64'hAB,                64'd0,                0, 3, 1, 1, 64'h00000000AB000000);
    add_vec(1'b0, 3'b011, 64'h08,                 64'd0,                 64'h00000000AB000000, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b010, 64'h12,                 64'd0,                 64'd0,                1, 1, 0, 0, 64'd0);
    add_vec(1'b1, 3'b100, 64'h08,                 64'hDEAD,              64'd0,                1, 1, 0, 0, 64'd0);
    add_vec(1'b0, 3'b111, 64'h10,                 64'd0,                 64'd0,                1, 1, 0, 0, 64'd0);
    add_vec(1'b1, 3'b011, 64'h1FF8,               64'h0123456789ABCDEF,  64'd0,                0, 2, 0, 1, 64'h0123456789ABCDEF);
    add_vec(1'b0, 3'b011, 64'h3FF8,               64'd0,                 64'h0123456789ABCDEF, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b011, 64'h1FF8,               64'd0,                 64'h0123456789ABCDEF, 0, 2, 1, 0, 64'd0);
    add_vec(1'b1, 3'b001, 64'h0E,                 64'h1234BEEF,          64'd0,                0, 3, 1, 1, 64'hBEEF0000AB000000);
    add_vec(1'b0, 3'b011, 64'h08,                 64'd0,                 64'hBEEF0000AB000000, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b000, 64'h0F,                 64'd0,                 64'hFFFFFFFFFFFFFFBE, 0, 2, 1, 0, 64'd0);
    add_vec(1'b0, 3'b001, 64'h11,                 64'd0,                 64'd0,                1, 1, 0, 0, 64'd0);
    add_vec(1'b0, 3'b011, 64'h0C,                 64'd0,                 64'd0,                1, 1, 0, 0, 64'd0);
    add_vec(1'b1, 3'b010, 64'h0A,                 64'h55,                64'd0,                1, 1, 0, 0, 64'd0);
    add_vec(1'b0, 3'b011, 64'hFFFF000000000010,   64'd0,                 64'h8877665544332211, 0, 2, 1, 0, 64'd0);

    foreach (vecs[i]) begin
      do_req(vecs[i].wr, vecs[i].f3, vecs[i].addr, vecs[i].wdata,
             got_rdata, got_err, got_lat, got_rd, got_wr);
      check($sformatf("vec%0d_rdata", i), got_rdata, vecs[i].exp_rdata);
      check($sformatf("vec%0d_err", i), got_err, vecs[i].exp_err);
      check($sformatf("vec%0d_latency", i), 64'(got_lat), 64'(vecs[i].exp_lat));
      check($sformatf("vec%0d_reads", i), 64'(got_rd), 64'(vecs[i].exp_rd));
      check($sformatf("vec%0d_writes", i), 64'(got_wr), 64'(vecs[i].exp_wr));
      if (vecs[i].exp_wr != 0) check($sformatf("vec%0d_wdata", i), last_wdata, vecs[i].exp_wdata);
    end
    check("mem1_final", mem[1], 64'hBEEF0000AB000000);
    check("mem1023_final", mem[1023], 64'h0123456789ABCDEF);

    // Back-to-back with req_valid held high: SD idx5, SD idx6, LD idx5.
    begin
      logic        bw [3];
      logic [2:0]  bf [3];
      logic [63:0] ba [3];
      logic [63:0] bd [3];
      int          acc_cyc [3];
      logic [63:0] resp_q [$];
      int accepted, cyc, rb0;
      logic just_acc;
      bw[0] = 1'b1; bf[0] = 3'b011; ba[0] = 64'h28; bd[0] = 64'hA5A5_1111_2222_3333;
      bw[1] = 1'b1; bf[1] = 3'b011; ba[1] = 64'h30; bd[1] = 64'h5A5A_4444_5555_6666;
      bw[2] = 1'b0; bf[2] = 3'b011; ba[2] = 64'h28; bd[2] = 64'd0;
      accepted = 0; cyc = 0;
      @(negedge clk);
      rb0 = ready_bad_cnt;
      req_valid = 1'b1; req_write = bw[0]; req_funct3 = bf[0]; req_addr = ba[0]; req_wdata = bd[0];
      while (accepted < 3 && cyc < 40) begin
        just_acc = req_ready;
        if (just_acc) begin acc_cyc[accepted] = cyc; accepted++; end
        if (resp_valid) resp_q.push_back(resp_rdata);
        @(posedge clk); cyc++;
        @(negedge clk);
        if (just_acc) begin
          if (accepted < 3) begin
            req_write = bw[accepted]; req_funct3 = bf[accepted];
            req_addr = ba[accepted]; req_wdata = bd[accepted];
          end else req_valid = 1'b0;
        end
      end
      for (int i = 0; i < 10 && resp_q.size() < 3; i++) begin
        if (resp_valid) resp_q.push_back(resp_rdata);
        if (resp_q.size() < 3) @(negedge clk);
      end
      check("b2b_accepted", 64'(accepted), 3);
      if (accepted == 3) begin
        check("b2b_gap01", 64'(acc_cyc[1] - acc_cyc[0]), 3);
        check("b2b_gap12", 64'(acc_cyc[2] - acc_cyc[1]), 3);
      end
      check("b2b_resp_count", 64'(resp_q.size()), 3);
      if (resp_q.size() == 3) begin
        check("b2b_resp0", resp_q[0], 0);
        check("b2b_resp2", resp_q[2], 64'hA5A5_1111_2222_3333);
      end
      check("b2b_mem5", mem[5], 64'hA5A5_1111_2222_3333);
      check("b2b_mem6", mem[6], 64'h5A5A_4444_5555_6666);
      check("b2b_ready_outside_idle", 64'(ready_bad_cnt - rb0), 0);
    end

    // Asynchronous reset during the WRITE cycle of a sub-word store.
    preload(10'd7, 64'h5555_5555_5555_5555);
    @(negedge clk);
    req_valid = 1'b1; req_write = 1'b1; req_funct3 = 3'b000; req_addr = 64'h38; req_wdata = 64'h77;
    for (int i = 0; i < 20 && !req_ready; i++) @(negedge clk);
    @(posedge clk);
    #1 req_valid = 1'b0;
    for (int i = 0; i < 5 && !mem_write; i++) @(negedge clk);
    check("rstw_in_write", mem_write, 1);
    #2 reset_n = 1'b0;
    #1;
    check("rstw_mem_write", mem_write, 0);
    check("rstw_mem_read", mem_read, 0);
    check("rstw_req_ready", req_ready, 1);
    check("rstw_resp_valid", resp_valid, 0);
    check("rstw_resp_err", resp_err, 0);
    check("rstw_resp_rdata", resp_rdata, 0);
    check("rstw_mem_addr", mem_addr, 0);
    check("rstw_mem_wdata", mem_write_data, 0);
    @(posedge clk);
    #1 check("rstw_mem7_untouched", mem[7], 64'h5555_5555_5555_5555);
    @(negedge clk);
    reset_n = 1'b1;
    @(negedge clk);
    check("rstw_ready_after", req_ready, 1);
    check("rstw_no_write_after", mem_write, 0);

    // Randomized requests against the reference model.
    for (int i = 0; i < 16; i++) begin
      logic [63:0] w;
      w = {$urandom, $urandom};
      ref_mem[i] = w;
      preload(10'(i), w);
    end
    for (int n = 0; n < 150; n++) begin
      logic        wr;
      logic [2:0]  f3;
      logic [63:0] addr, wdata;
      int          sz, off;
      wr = 1'($urandom_range(0, 1));
      f3 = 3'($urandom_range(0, 7));
      sz = 1 << f3[1:0];
      off = int'($urandom_range(0, 7));
      if ($urandom_range(0, 3) != 0) off = off - (off % sz);
      addr = (64'($urandom_range(0, 7)) << 13) | (64'($urandom_range(0, 15)) << 3) | 64'(off);
      wdata = {$urandom, $urandom};
      model(wr, f3, addr, wdata, exp_rdata, exp_err, exp_lat, exp_rd, exp_wr);
      do_req(wr, f3, addr, wdata, got_rdata, got_err, got_lat, got_rd, got_wr);
      check($sformatf("rnd%0d_rdata", n), got_rdata, exp_rdata);
      check($sformatf("rnd%0d_err", n), got_err, exp_err);
      check($sformatf("rnd%0d_latency", n), 64'(got_lat), 64'(exp_lat));
      check($sformatf("rnd%0d_reads", n), 64'(got_rd), 64'(exp_rd));
      check($sformatf("rnd%0d_writes", n), 64'(got_wr), 64'(exp_wr));
    end
    for (int i = 0; i < 16; i++) check($sformatf("rnd_mem%0d", i), mem[i], ref_mem[i]);

    check("strobes_never_both", 64'(both_cnt), 0);
    check("mem_addr_stable_rmw", 64'(addr_bad_cnt), 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule

// File: doc/lsu_mem_master.md
Name: lsu_mem_master

Overview:
- Load/store initiator between the MEM pipeline stage and the 64-bit word-addressed data memory.
- Accepts one byte-addressed load or store per handshake, issues the memory-side read/write strobes, and returns a sized, extended load result.
- Performs read-modify-write for sub-doubleword stores; the memory has no byte enables.
- Flags misaligned and unsupported accesses without touching memory.

Parameters:
DATA_WIDTH, 64, memory word width in bits (fixed at 64; other values unsupported)
ADDR_WIDTH, 10, memory word-index width; memory holds 2**ADDR_WIDTH doublewords
XLEN, 64, width of the pipeline byte address

Ports:
clk  in  1  clock; all state updates on rising edge
reset_n  in  1  asynchronous, active-low reset
req_valid  in  1  pipeline request present
req_ready  out  1  block can accept a request
req_write  in  1  1 = store, 0 = load
req_funct3  in  3  RV64 funct3: loads 000 LB, 001 LH, 010 LW, 011 LD, 100 LBU, 101 LHU, 110 LWU; stores 000 SB, 001 SH, 010 SW, 011 SD
req_addr  in  XLEN  byte address
req_wdata  in  DATA_WIDTH  store data, right-aligned
resp_valid  out  1  one-cycle pulse: access complete
resp_rdata  out  DATA_WIDTH  extended load result (0 for stores and errors)
resp_err  out  1  valid with resp_valid: misaligned or unsupported funct3
mem_addr  out  ADDR_WIDTH  word index = captured req_addr[ADDR_WIDTH+2:3]
mem_write_data  out  DATA_WIDTH  word to write
mem_write  out  1  write strobe; memory writes on the clk edge
mem_read  out  1  read enable; memory read data is combinational
mem_read_data  in  DATA_WIDTH  memory read data (0 when mem_read is low)

Behaviour:
- Reset (reset_n low, asynchronous): state IDLE; req_ready=1; resp_valid=0, resp_err=0, resp_rdata=0; mem_read=0, mem_write=0; mem_addr=0, mem_write_data=0; all capture registers cleared.
- FSM states: IDLE, ACCESS, WRITE, RESP.
- IDLE:
  - req_ready=1.
  - On req_valid&&req_ready: capture write, funct3, addr, wdata.
  - If the request is an error, go to RESP with err=1. Otherwise go to ACCESS.
  - Requests are ignored in every other state (req_ready=0).
- Error conditions:
  - Misaligned: H with addr[0]!=0; W with addr[1:0]!=0; D with addr[2:0]!=0.
  - Unsupported funct3: load 111; store funct3[2]=1.
  - Errored accesses never assert mem_read or mem_write.
- ACCESS, load: mem_read=1. Select the lane at byte offset addr[2:0]. Sign-extend LB/LH/LW; zero-extend LBU/LHU/LWU; LD passes through. Register the result into resp_rdata, then go to RESP.
- ACCESS, SD: mem_write=1, mem_write_data=wdata; go to RESP.
- ACCESS, SB/SH/SW: mem_read=1. Register a merged word: the read word with the sized lane at addr[2:0] replaced by the low bytes of wdata. Go to WRITE.
- WRITE: mem_write=1, mem_write_data=merged word; go to RESP.
- RESP: resp_valid=1 for exactly one cycle with resp_rdata/resp_err; go to IDLE.
  - resp_rdata=0 for stores and errors.
  - resp_rdata and resp_err return to 0 when resp_valid is low.
- Latency from handshake edge T:
  - load, SD, error: resp_valid during cycle T+2 (error: T+1).
  - SB/SH/SW: resp_valid during cycle T+3.
  - Next request is accepted the cycle after RESP.
- Strobe rules:
  - mem_read and mem_write are never high together.
  - Each is high for at most one cycle per access.
  - mem_addr is held stable from ACCESS through WRITE.
- Address width: req_addr bits above ADDR_WIDTH+2 are ignored (memory wraps). Address 0x1FF8 with ADDR_WIDTH=10 maps to index 1023.
- Reset mid-operation: the FSM aborts to IDLE immediately and no further strobes are issued. A write already clocked is not undone.

Test Plan:
- Load LD: reset, preload mem[2]=0x8877_6655_4433_2211. LD addr 0x10 -> resp_valid at T+2, rdata=0x8877665544332211, err=0; mem_read high exactly one cycle.
- Sign/zero extension: same word. LB addr 0x17 -> 0xFFFFFFFFFFFFFF88. LBU addr 0x17 -> 0x88. LH 0x16 -> 0xFFFFFFFFFFFF8877. LWU 0x14 -> 0x88776655.
- Sub-word store RMW: mem[1]=0. SB addr 0x0B, wdata 0xAB -> read cycle, then write cycle with 0x0000_0000_AB00_0000; resp at T+3. Readback LD 0x08 confirms the value.
- Misaligned/unsupported: LW addr 0x12 -> resp_valid at T+1, err=1, rdata=0, no mem strobes. Store funct3 100 -> err=1.
- Back-to-back and backpressure: req_valid held high for 3 requests. req_ready is low outside IDLE; each request is accepted exactly once, in order; SD data written on the ACCESS edge.
- Async reset during WRITE: deassert reset_n mid-cycle -> mem_write drops immediately, all outputs at reset values, req_ready=1 after release.
